// File: rtl/fxp_round_sat.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_round_sat
//  Description : Two-stage pipelined fixed-point requantiser. Each lane takes
//                an arithmetic right shift with one of four rounding modes,
//                then saturates (FXP_ROUND_SAT_EN defined) or wraps to
//                OUT_WIDTH bits. Valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp_round_sat #(
    parameter int IN_WIDTH  = 40,
    parameter int OUT_WIDTH = 20,
    parameter int LANES     = 2,
    parameter int SHW       = $clog2(IN_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*IN_WIDTH-1:0]      in_dat,
    input  logic [SHW-1:0]                 in_shift,
    input  logic [1:0]                     in_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*OUT_WIDTH-1:0]     out_dat,
    output logic [LANES-1:0]               out_ovf,
    output logic                           ovf_sticky,
    input  logic                           clr_ovf
);

    localparam logic [1:0] c_mode_floor = 2'd0;
    localparam logic [1:0] c_mode_hup   = 2'd1;
    localparam logic [1:0] c_mode_even  = 2'd2;
    localparam logic [1:0] c_mode_zero  = 2'd3;

    localparam logic [SHW-1:0]      c_nmax = SHW'(IN_WIDTH - 1);
    localparam logic [IN_WIDTH-1:0] c_one  = IN_WIDTH'(1);

    logic                               w_adv;
    logic [SHW-1:0]                     w_n;
    logic [SHW-1:0]                     w_nm1;
    logic                               w_nz;
    logic [LANES-1:0][IN_WIDTH-1:0]     w_s1_q;
    logic [LANES-1:0]                   w_s1_inc;
    logic [LANES-1:0][OUT_WIDTH-1:0]    w_s2_dat;

    logic                               r_s1_vld;
    logic [LANES-1:0][IN_WIDTH-1:0]     r_s1_q;
    logic [LANES-1:0]                   r_s1_inc;
    logic                               r_out_vld;
    logic [LANES-1:0][OUT_WIDTH-1:0]    r_out_dat;

    // Both stages move as one; a bubble in S1 is carried, not squeezed out.
    assign w_adv    = !r_out_vld || out_ready;
    assign in_ready = w_adv;

    assign w_n   = (in_shift > c_nmax) ? c_nmax : in_shift;
    assign w_nz  = (w_n != '0);
    assign w_nm1 = w_n - SHW'(1);

    // ------------------------------------------------------------------
    // Stage 1: floor quotient and rounding increment per lane
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LANES; k++) begin : g_s1
        logic signed [IN_WIDTH-1:0] w_x;
        logic signed [IN_WIDTH-1:0] w_q;
        logic        [IN_WIDTH-1:0] w_mask;
        logic        [IN_WIDTH-1:0] w_d;
        logic        [IN_WIDTH-1:0] w_h;
        logic                       w_inc;

        assign w_x    = $signed(in_dat[k*IN_WIDTH +: IN_WIDTH]);
        assign w_q    = w_x >>> w_n;
        assign w_mask = (c_one << w_n) - c_one;
        assign w_d    = w_x & w_mask;
        assign w_h    = c_one << w_nm1;

        // With N = 0 there are no dropped bits, so every mode passes x through.
        always_comb begin
            w_inc = 1'b0;
            if (w_nz) begin
                case (in_mode)
                    c_mode_floor: w_inc = 1'b0;
                    c_mode_hup:   w_inc = (w_d >= w_h);
                    c_mode_even:  w_inc = (w_d > w_h) || ((w_d == w_h) && w_q[0]);
                    c_mode_zero:  w_inc = w_x[IN_WIDTH-1] && (w_d != '0);
                    default:      w_inc = 1'b0;
                endcase
            end
        end

        assign w_s1_q[k]   = w_q;
        assign w_s1_inc[k] = w_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_q   <= '0;
            r_s1_inc <= '0;
        end else if (w_adv) begin
            r_s1_vld <= in_valid;
            r_s1_q   <= w_s1_q;
            r_s1_inc <= w_s1_inc;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: add increment one bit wider, then saturate or wrap
    // ------------------------------------------------------------------
`ifdef FXP_ROUND_SAT_EN
    localparam logic signed [IN_WIDTH:0] c_sat_max =
        {{(IN_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] c_sat_min = ~c_sat_max;
    localparam logic [OUT_WIDTH-1:0]     c_out_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0]     c_out_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [LANES-1:0] w_s2_ovf;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_s2
        logic signed [IN_WIDTH:0] w_r;

        assign w_r = $signed({r_s1_q[k][IN_WIDTH-1], r_s1_q[k]})
                   + $signed({{IN_WIDTH{1'b0}}, r_s1_inc[k]});

`ifdef FXP_ROUND_SAT_EN
        logic w_hi;
        logic w_lo;

        assign w_hi        = (w_r > c_sat_max);
        assign w_lo        = (w_r < c_sat_min);
        assign w_s2_dat[k] = w_hi ? c_out_max : (w_lo ? c_out_min : w_r[OUT_WIDTH-1:0]);
        assign w_s2_ovf[k] = w_hi | w_lo;
`else
        logic [IN_WIDTH-OUT_WIDTH:0] w_unused_hi;

        assign w_s2_dat[k] = w_r[OUT_WIDTH-1:0];
        assign w_unused_hi = w_r[IN_WIDTH:OUT_WIDTH];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
        end else if (w_adv) begin
            r_out_vld <= r_s1_vld;
            r_out_dat <= w_s2_dat;
        end
    end

`ifdef FXP_ROUND_SAT_EN
    logic [LANES-1:0] r_out_ovf;
    logic             r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_ovf <= '0;
        end else if (w_adv) begin
            r_out_ovf <= w_s2_ovf;
        end
    end

    // A saturating beat leaving the block beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (r_out_vld && out_ready && (|r_out_ovf)) begin
            r_sticky <= 1'b1;
        end else if (clr_ovf) begin
            r_sticky <= 1'b0;
        end
    end

    assign out_ovf    = r_out_ovf;
    assign ovf_sticky = r_sticky;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_ovf;
    assign out_ovf      = '0;
    assign ovf_sticky   = 1'b0;
`endif

    assign out_valid = r_out_vld;
    assign out_dat   = r_out_dat;

endmodule
`default_nettype wire

// File: tb/tb_fxp_round_sat.sv
`default_nettype none
// Testbench for fxp_round_sat: directed and random beats scored against a
// plain-arithmetic reference model; saturation checks follow FXP_ROUND_SAT_EN.
module tb_fxp_round_sat;

    localparam int IW = 40;
    localparam int OW = 20;
    localparam int L  = 2;
    localparam int SW = 6;

    typedef struct {
        logic [L*OW-1:0] dat;
        logic [L-1:0]    ovf;
        int              cyc;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [L*IW-1:0] in_dat = '0;
    logic [SW-1:0]   in_shift = '0;
    logic [1:0]      in_mode = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [L*OW-1:0] out_dat;
    logic [L-1:0]    out_ovf;
    logic            ovf_sticky;
    logic            clr_ovf = 1'b0;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_out   = 0;
    int    cyc     = 0;
    int    or_mode = 0;
    int    pidx    = 0;
    bit    lat_chk = 1'b0;
    bit    rst_prev = 1'b1;
    bit    stall_prev = 1'b0;
    bit    sticky_m = 1'b0;
    bit    ovr_en = 1'b0;
    logic [L*OW-1:0] ovr_dat = '0;
    logic [L-1:0]    ovr_ovf = '0;
    logic [L*OW-1:0] prev_dat;
    logic [L-1:0]    prev_ovf;
    logic [3:0]      or_pat = 4'b1001;
    beat_t           sb[$];

    fxp_round_sat #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .LANES    (L),
        .SHW      (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dat    (in_dat),
        .in_shift  (in_shift),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dat   (out_dat),
        .out_ovf   (out_ovf),
        .ovf_sticky(ovf_sticky),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: round x/2^n by the rule of the mode, as plain integers.
    function automatic longint lane_round(input longint x, input int n, input int md);
        longint q, d, h;
        bit     inc;
        if (n == 0) return x;
        q = x >>> n;
        d = x - (q <<< n);
        h = 64'sd1 <<< (n - 1);
        case (md)
            1:       inc = (d >= h);
            2:       inc = (d > h) || ((d == h) && q[0]);
            3:       inc = (x < 0) && (d != 0);
            default: inc = 1'b0;
        endcase
        return q + (inc ? 64'sd1 : 64'sd0);
    endfunction

    function automatic beat_t model(input logic [L*IW-1:0] dat, input logic [SW-1:0] sh,
                                    input logic [1:0] md);
        beat_t       b;
        int          n;
        longint      x, r;
        logic [IW-1:0] v;
`ifdef FXP_ROUND_SAT_EN
        longint      maxp, minn;
        maxp = (64'sd1 <<< (OW - 1)) - 1;
        minn = -maxp - 1;
`endif
        n = (int'(sh) >= IW) ? IW - 1 : int'(sh);
        b.dat = '0;
        b.ovf = '0;
        b.cyc = 0;
        for (int k = 0; k < L; k++) begin
            v = dat[k*IW +: IW];
            x = longint'($signed(v));
            r = lane_round(x, n, int'(md));
`ifdef FXP_ROUND_SAT_EN
            if (r > maxp) begin
                r = maxp;
                b.ovf[k] = 1'b1;
            end else if (r < minn) begin
                r = minn;
                b.ovf[k] = 1'b1;
            end
`endif
            b.dat[k*OW +: OW] = OW'(r);
        end
        return b;
    endfunction

    always @(posedge clk) begin
        #1;
        case (or_mode)
            1: begin
                out_ready = or_pat[pidx];
                pidx = (pidx + 1) % 4;
            end
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            sb.delete();
            rst_prev   = 1'b1;
            stall_prev = 1'b0;
            sticky_m   = 1'b0;
        end else begin
            if (rst_prev) check_eq("rst_flush_valid", out_valid, 0);
            rst_prev = 1'b0;
            check_eq("sticky", ovf_sticky, sticky_m);
            check_eq("in_ready", in_ready, !(out_valid && !out_ready));
            if (stall_prev) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_dat", out_dat, prev_dat);
                check_eq("hold_ovf", out_ovf, prev_ovf);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_beat", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("out_dat", out_dat, e.dat);
                    check_eq("out_ovf", out_ovf, e.ovf);
                    if (lat_chk) check_eq("latency", cyc - e.cyc, 2);
                    if (|e.ovf) sticky_m = 1'b1;
                    else if (clr_ovf) sticky_m = 1'b0;
                end
            end else if (clr_ovf) begin
                sticky_m = 1'b0;
            end
`ifndef FXP_ROUND_SAT_EN
            sticky_m = 1'b0;
`endif
            if (in_valid && in_ready) begin
                e = model(in_dat, in_shift, in_mode);
                if (ovr_en) begin
                    e.dat = ovr_dat;
                    e.ovf = ovr_ovf;
                end
                e.cyc = cyc;
                sb.push_back(e);
            end
            stall_prev = out_valid && !out_ready;
            prev_dat   = out_dat;
            prev_ovf   = out_ovf;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input longint x0, input longint x1, input int sh, input int md,
                        input bit ov, input longint e0, input longint e1, input logic [1:0] eo);
        bit acc = 1'b0;
        in_dat   = {IW'(x1), IW'(x0)};
        in_shift = SW'(sh);
        in_mode  = 2'(md);
        ovr_en   = ov;
        ovr_dat  = {OW'(e1), OW'(e0)};
        ovr_ovf  = eo;
        in_valid = 1'b1;
        for (int i = 0; i < 1000 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check_eq("send_timeout", acc, 1);
        in_valid = 1'b0;
        ovr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) idle(1);
        idle(2);
        check_eq("drain", sb.size(), 0);
    endtask

    function automatic longint rand_x();
        logic [IW-1:0] v;
        case ($urandom_range(0, 3))
            0: v = IW'({$urandom(), $urandom()});
            1: v = IW'(longint'($urandom_range(0, 2000)) - 1000);
            2: v = IW'(($urandom_range(0, 1) ? 64'sd1 : -64'sd1)
                       * ((64'sd1 <<< (OW - 1)) + longint'($urandom_range(0, 8)) - 4));
            default: v = $urandom_range(0, 1) ? {1'b0, {(IW-1){1'b1}}} : {1'b1, {(IW-1){1'b0}}};
        endcase
        return longint'($signed(v));
    endfunction

    function automatic int rand_sh();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3));
    endfunction

    initial begin
        longint tx [3];
        longint te0[3][4];
        longint te1[3][4];
        int     n0;

        tx  = '{5, -5, 7};
        te0 = '{'{2, 3, 2, 2}, '{-3, -2, -2, -2}, '{3, 4, 4, 3}};
        te1 = '{'{-3, -2, -2, -2}, '{2, 3, 2, 2}, '{-4, -3, -4, -3}};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_out_dat", out_dat, 0);
        check_eq("reset_out_ovf", out_ovf, 0);
        check_eq("reset_sticky", ovf_sticky, 0);
        check_eq("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Rounding-mode table at N = 1, lane 1 carries -x.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++)
            for (int m = 0; m < 4; m++)
                send(tx[i], -tx[i], 1, m, 1'b1, te0[i][m], te1[i][m], 2'b00);

        for (int m = 0; m < 4; m++)
            send(12345, -777, 0, m, 1'b1, 12345, -777, 2'b00);

        // Shift 63 clamps to 39.
        send(64'sh7F_FFFF_FFFF, -(64'sd1 <<< 39), 63, 1, 1'b1, 1, -1, 2'b00);
        drain();

`ifdef FXP_ROUND_SAT_EN
        send(64'sd1 <<< 30, -(64'sd1 <<< 30), 0, 0, 1'b1, 524287, -524288, 2'b11);
        send(64'sd1 <<< 30, 5, 0, 1, 1'b1, 524287, 5, 2'b01);
        drain();
        check_eq("sticky_set", ovf_sticky, 1);
`else
        send((64'sd1 <<< 30) + 3, -(64'sd1 <<< 30), 0, 0, 1'b1, 3, 0, 2'b00);
        drain();
        check_eq("sticky_off", ovf_sticky, 0);
`endif
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        idle(1);
        check_eq("sticky_clr", ovf_sticky, 0);

        // Backpressure with out_ready cycling 1,0,0,1.
        lat_chk = 1'b0;
        pidx    = 0;
        or_mode = 1;
        n0      = n_out;
        for (int i = 0; i < 8; i++)
            send(rand_x(), rand_x(), rand_sh(), int'($urandom_range(0, 3)), 1'b0, 0, 0, 2'b00);
        drain();
        check_eq("bp_count", n_out - n0, 8);

        // Random traffic with random stalls and gaps.
        or_mode = 2;
        for (int i = 0; i < 300; i++) begin
            idle(int'($urandom_range(0, 1)));
            if ($urandom_range(0, 15) == 0) clr_ovf = 1'b1;
            send(rand_x(), rand_x(), rand_sh(), int'($urandom_range(0, 3)), 1'b0, 0, 0, 2'b00);
            clr_ovf = 1'b0;
        end
        drain();

        // Reset with two beats in flight.
        or_mode = 0;
        idle(2);
        lat_chk = 1'b1;
        send(rand_x(), rand_x(), rand_sh(), 1, 1'b0, 0, 0, 2'b00);
        send(rand_x(), rand_x(), rand_sh(), 2, 1'b0, 0, 0, 2'b00);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(6);
        send(-9, 9, 2, 2, 1'b1, -2, 2, 2'b00);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
